// File: rtl/ghost_pkg.sv
// Shared types for the ghost movement path: tile coordinates, direction and mover state encodings.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package ghost_pkg;

    typedef logic [4:0] coord_t;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_LEFT  = 3'd1,
        DIR_RIGHT = 3'd2,
        DIR_UP    = 3'd3,
        DIR_DOWN  = 3'd4
    } dir_t;

    typedef enum logic [1:0] {
        SPAWN_WAIT = 2'd0,
        EXIT       = 2'd1,
        ROAM       = 2'd2
    } mover_state_t;

    // Reverse of a direction; DIR_NONE (and any illegal code) stays DIR_NONE.
    function automatic dir_t dir_opposite(input dir_t d);
        case (d)
            DIR_LEFT:  dir_opposite = DIR_RIGHT;
            DIR_RIGHT: dir_opposite = DIR_LEFT;
            DIR_UP:    dir_opposite = DIR_DOWN;
            DIR_DOWN:  dir_opposite = DIR_UP;
            default:   dir_opposite = DIR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/move_tick_gen.sv
// Movement-rate divider: tick is high for one cycle out of every MOVE_DIV (every cycle when MOVE_DIV=1).
// Latency: tick is combinational from the counter; first tick MOVE_DIV cycles after reset/clear.
// Backpressure: none; clear restarts the count from zero on the next edge.
// Ports: clk, reset (async, active-high), clear (sync restart), tick (out).
module move_tick_gen #(
    parameter int MOVE_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(MOVE_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/ghost_mover.sv
// Ghost mover: turns one-hot direction requests into registered tile coordinates with pen exit,
//   wall blocking, tunnel wrap on x and respawn on capture.
// Latency: coordinates update on the movement-tick edge; step_done follows for exactly one cycle.
// Backpressure: none; requests are sampled only on ticks, anything else is ignored.
// Ports: clk, reset (async, active-high), ghost_left/right/up/down (requests), wall_left/right/up/down
//   (maze lookup at current tile), caught (sync respawn), ghost_x/ghost_y, cur_dir (dir_t), in_pen, step_done.
// Option: GHOST_MOVER_FRIGHT_EN adds input fright (half-rate, reversed requests while roaming).
import ghost_pkg::*;

module ghost_mover #(
    parameter int GRID_W        = 20,
    parameter int GRID_H        = 22,
    parameter int SPAWN_X       = 10,
    parameter int SPAWN_Y       = 11,
    parameter int EXIT_Y        = 9,
    parameter int MOVE_DIV      = 4,
    parameter int RESPAWN_TICKS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ghost_left,
    input  logic       ghost_right,
    input  logic       ghost_up,
    input  logic       ghost_down,
    input  logic       wall_left,
    input  logic       wall_right,
    input  logic       wall_up,
    input  logic       wall_down,
    input  logic       caught,
`ifdef GHOST_MOVER_FRIGHT_EN
    input  logic       fright,
`endif
    output logic [4:0] ghost_x,
    output logic [4:0] ghost_y,
    output logic [2:0] cur_dir,
    output logic       in_pen,
    output logic       step_done
);

    localparam coord_t X_MAX = coord_t'(GRID_W - 1);
    localparam coord_t Y_MAX = coord_t'(GRID_H - 1);
    localparam coord_t SP_X  = coord_t'(SPAWN_X);
    localparam coord_t SP_Y  = coord_t'(SPAWN_Y);
    localparam coord_t EX_Y  = coord_t'(EXIT_Y);

    localparam int WW = (RESPAWN_TICKS > 1) ? $clog2(RESPAWN_TICKS) : 1;
    localparam logic [WW-1:0] WAIT_LAST = (RESPAWN_TICKS > 0) ? WW'(RESPAWN_TICKS - 1) : '0;

    mover_state_t  state_q, state_d;
    coord_t        x_q, x_d, y_q, y_d;
    dir_t          dir_q, dir_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          step_q, step_d;

    logic   tick;
    logic   move_tick;
    dir_t   req;
    dir_t   eff_req;
    dir_t   mv_dir;
    coord_t y_exit;
    logic   open_left, open_right, open_up, open_down;

    move_tick_gen #(
        .MOVE_DIV (MOVE_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (caught),
        .tick  (tick)
    );

    // Anything other than exactly one request bit is treated as no request.
    always_comb begin
        req = DIR_NONE;
        case ({ghost_left, ghost_right, ghost_up, ghost_down})
            4'b1000: req = DIR_LEFT;
            4'b0100: req = DIR_RIGHT;
            4'b0010: req = DIR_UP;
            4'b0001: req = DIR_DOWN;
            default: req = DIR_NONE;
        endcase
    end

`ifdef GHOST_MOVER_FRIGHT_EN
    // Phase toggles on each roaming tick while frightened; only every second tick moves.
    logic fphase_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fphase_q <= 1'b0;
        end else if (caught || (state_q != ROAM) || !fright) begin
            fphase_q <= 1'b0;
        end else if (tick) begin
            fphase_q <= ~fphase_q;
        end
    end

    assign move_tick = tick && (!fright || fphase_q);
    assign eff_req   = fright ? dir_opposite(req) : req;
`else
    assign move_tick = tick;
    assign eff_req   = req;
`endif

    // y never wraps, so the grid edges act as extra walls for UP/DOWN.
    assign open_left  = !wall_left;
    assign open_right = !wall_right;
    assign open_up    = !wall_up   && (y_q != '0);
    assign open_down  = !wall_down && (y_q != Y_MAX);

    function automatic logic dir_open(input dir_t d, input logic ol, input logic or_,
                                      input logic ou, input logic od);
        case (d)
            DIR_LEFT:  dir_open = ol;
            DIR_RIGHT: dir_open = or_;
            DIR_UP:    dir_open = ou;
            DIR_DOWN:  dir_open = od;
            default:   dir_open = 1'b0;
        endcase
    endfunction

    // x wraps through the side tunnel.
    function automatic coord_t step_x(input dir_t d, input coord_t x);
        case (d)
            DIR_LEFT:  step_x = (x == '0) ? X_MAX : x - 5'd1;
            DIR_RIGHT: step_x = (x == X_MAX) ? '0 : x + 5'd1;
            default:   step_x = x;
        endcase
    endfunction

    function automatic coord_t step_y(input dir_t d, input coord_t y);
        case (d)
            DIR_UP:   step_y = y - 5'd1;
            DIR_DOWN: step_y = y + 5'd1;
            default:  step_y = y;
        endcase
    endfunction

    assign y_exit = y_q - 5'd1;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        wait_d  = wait_q;
        mv_dir  = DIR_NONE;

        case (state_q)
            SPAWN_WAIT: begin
                if (RESPAWN_TICKS == 0) begin
                    state_d = EXIT;
                end else if (tick) begin
                    if (wait_q == WAIT_LAST) begin
                        state_d = EXIT;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
            end
            EXIT: begin
                // Pen door: walls and requests do not apply on the way out.
                if (tick) begin
                    y_d   = y_exit;
                    dir_d = DIR_UP;
                    if (y_exit == EX_Y) begin
                        state_d = ROAM;
                    end
                end
            end
            ROAM: begin
                if (move_tick) begin
                    if ((eff_req != DIR_NONE) &&
                        dir_open(eff_req, open_left, open_right, open_up, open_down)) begin
                        mv_dir = eff_req;
                        dir_d  = eff_req;
                    end else if ((dir_q != DIR_NONE) &&
                                 dir_open(dir_q, open_left, open_right, open_up, open_down)) begin
                        mv_dir = dir_q;
                    end else begin
                        dir_d = DIR_NONE;
                    end
                    x_d = step_x(mv_dir, x_q);
                    y_d = step_y(mv_dir, y_q);
                end
            end
            default: begin
                state_d = SPAWN_WAIT;
            end
        endcase

        // Capture overrides everything, including a move on the same tick.
        if (caught) begin
            state_d = SPAWN_WAIT;
            x_d     = SP_X;
            y_d     = SP_Y;
            dir_d   = DIR_NONE;
            wait_d  = '0;
        end

        step_d = !caught && ((x_d != x_q) || (y_d != y_q));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SPAWN_WAIT;
            x_q     <= SP_X;
            y_q     <= SP_Y;
            dir_q   <= DIR_NONE;
            wait_q  <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            wait_q  <= wait_d;
            step_q  <= step_d;
        end
    end

    assign ghost_x   = x_q;
    assign ghost_y   = y_q;
    assign cur_dir   = dir_q;
    assign in_pen    = (state_q != ROAM);
    assign step_done = step_q;

endmodule

// File: doc/ghost_mover.md
Name: ghost_mover

Overview:
- Consumer end of the ghost direction interface. Takes one-hot direction requests from the ghost chase logic and turns them into registered tile coordinates ghost_x/ghost_y on the 5-bit maze grid.
- Applies the move-rate divider, wall blocking, tunnel wrap, spawn-pen exit sequencing and respawn on capture.
- Its ghost_x/ghost_y outputs feed back into the chase logic and the sprite renderer.

Parameters:
- GRID_W, 20: tiles per row; legal x range is 0..GRID_W-1 (GRID_W ≤ 32).
- GRID_H, 22: tiles per column; legal y range is 0..GRID_H-1.
- SPAWN_X, 10: x coordinate loaded on reset or capture.
- SPAWN_Y, 11: y coordinate loaded on reset or capture.
- EXIT_Y, 9: y coordinate at which the pen exit completes.
- MOVE_DIV, 4: clocks per movement tick (≥1).
- RESPAWN_TICKS, 8: movement ticks spent waiting in the pen before exiting.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ghost_left  in  1  direction request, left
- ghost_right  in  1  direction request, right
- ghost_up  in  1  direction request, up
- ghost_down  in  1  direction request, down
- wall_left  in  1  tile at (x-1, y) is wall; from maze lookup at current position
- wall_right  in  1  tile at (x+1, y) is wall
- wall_up  in  1  tile at (x, y-1) is wall
- wall_down  in  1  tile at (x, y+1) is wall
- caught  in  1  ghost captured; force respawn
- ghost_x  out  5  current tile x
- ghost_y  out  5  current tile y
- cur_dir  out  3  last applied direction, dir_t encoding
- in_pen  out  1  high in SPAWN_WAIT and EXIT
- step_done  out  1  one-cycle pulse when a coordinate changed

Behaviour:
- Reset (async assert, sync release) sets:
  - ghost_x=SPAWN_X, ghost_y=SPAWN_Y
  - state=SPAWN_WAIT, cur_dir=DIR_NONE
  - step_done=0, in_pen=1
  - tick counter=0, wait counter=0
- Tick: the counter counts 0..MOVE_DIV-1 and wraps. tick is high during the cycle the counter equals MOVE_DIV-1. MOVE_DIV=1 gives a tick every cycle.
- Request decode: exactly one of the four request bits high gives a valid req. Zero or more than one bit high gives req=NONE.
- SPAWN_WAIT:
  - Each tick increments the wait counter.
  - On the tick where wait counter==RESPAWN_TICKS-1, go to EXIT.
  - RESPAWN_TICKS=0 goes to EXIT on the first clock edge.
  - Position is held.
- EXIT:
  - Each tick: ghost_y−1, cur_dir=UP. Requests and walls are ignored (pen door).
  - When the updated y equals EXIT_Y, go to ROAM on the same edge.
- ROAM, on each tick:
  - If req is not NONE and that side is not walled, move in req and set cur_dir=req.
  - Otherwise, if cur_dir is not NONE and that side is not walled, continue in cur_dir.
  - Otherwise hold and set cur_dir=NONE.
- Arithmetic and edges:
  - x wraps: LEFT at x=0 goes to GRID_W-1; RIGHT at x=GRID_W-1 goes to 0 (tunnel).
  - y never wraps: UP at y=0 and DOWN at y=GRID_H-1 are treated as blocked regardless of the wall inputs.
- Coordinate outputs register on the tick edge. step_done is high for exactly the following cycle, and only if x or y changed.
- caught is synchronous and has highest priority, in any state, including the same cycle as a tick. It:
  - loads the spawn coordinates
  - sets state=SPAWN_WAIT
  - clears both counters
  - sets cur_dir=NONE
  - sets step_done=0
- caught held high keeps the block in SPAWN_WAIT with counters cleared.
- Reset asserted mid-move aborts the move immediately. No partial update is visible.

Optional Feature:
- Macro GHOST_MOVER_FRIGHT_EN. When defined:
  - Adds input fright (1 bit).
  - While fright=1 in ROAM, the effective tick period is 2×MOVE_DIV (every other tick is ignored).
  - While fright=1 in ROAM, req is reversed before the wall check (LEFT↔RIGHT, UP↔DOWN).
  - fright has no effect in SPAWN_WAIT or EXIT.
- When undefined: no fright port, and behaviour is exactly as above.

Decomposition:
- Package ghost_pkg holds:
  - typedef coord_t (logic [4:0])
  - enum dir_t: NONE=0, LEFT, RIGHT, UP, DOWN (3 bits)
  - enum mover_state_t: SPAWN_WAIT, EXIT, ROAM
  - a function returning the opposite of a dir_t
- One sub-module: move_tick_gen (parameter MOVE_DIV; inputs clk, reset, clear; output tick).
- Decode, wall check and state machine stay in ghost_mover.

Test Plan:
- Reset release, MOVE_DIV=4, RESPAWN_TICKS=8, no caught: position stays (10,11) for 32 clocks. The next ticks move y to 10, then 9. in_pen then drops and the state is ROAM, with step_done pulsing once per move.
- ROAM at (5,9), ghost_right=1, no walls: x goes 6, 7, 8 on successive ticks, cur_dir=RIGHT. Then wall_right=1 with req still RIGHT: position holds and cur_dir=NONE.
- ROAM at (5,9) with cur_dir=RIGHT, req=UP, wall_up=1: the ghost continues right to (6,9).
- ROAM at (0,9), ghost_left=1: next tick x=19. At (19,9), ghost_right=1: next tick x=0.
- ROAM with ghost_left=1 and ghost_up=1 together: treated as NONE, so the ghost continues in cur_dir. caught pulsed in the same cycle as a tick: the next cycle shows (10,11), in_pen=1, step_done=0.
- With GHOST_MOVER_FRIGHT_EN, fright=1, ghost_right=1 at (8,9), no walls: x goes to 7 only once per 8 clocks.
